fetch_fd_stage: RTL and testbench

- Fetch stage plus F/D pipeline register of the 5-stage MIPS core.
- Owns the PC and drives the instruction-memory read address.
- Latches the instruction, PC and PC+8 into the D stage.
- Obeys the `pause` from the hazard/stall unit; accepts branch/jump redirects resolved in D, using delay-slot semantics with no flush.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_fd_stage_if.sv | 27 ++
 rtl/pc_gen.sv | 24 ++
 rtl/fetch_fd_stage.sv | 105 ++++++++++
 tb/tb_fetch_fd_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch/decode front end.
package mips_pkg;

  localparam int unsigned IM_AW_DEF    = 10;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // F/D pipeline register payload
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } fd_t;

endpackage

// File: rtl/fetch_fd_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, IM port and F/D outputs.
interface fetch_fd_stage_if #(
  parameter int unsigned IM_AW = mips_pkg::IM_AW_DEF
);
  logic             pause;
  logic             redirect_D;
  logic [31:0]      target_D;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  logic [31:0]      PC_F;
  logic [31:0]      IR_D;
  logic [31:0]      PC_D;
  logic [31:0]      PC8_D;
  logic             valid_D;
  logic             fault;
  logic [31:0]      stall_cnt;

  modport master (
    input  pause, redirect_D, target_D, im_rdata,
    output im_addr, PC_F, IR_D, PC_D, PC8_D, valid_D, fault, stall_cnt
  );

  modport slave (
    output pause, redirect_D, target_D, im_rdata,
    input  im_addr, PC_F, IR_D, PC_D, PC8_D, valid_D, fault, stall_cnt
  );
endinterface

// File: rtl/pc_gen.sv
// Next-PC mux, +4/+8 adders, IM word address and range/alignment fault check.
module pc_gen #(
  parameter logic [31:0] IM_BASE = 32'h0000_3000,
  parameter int unsigned IM_AW   = 10
) (
  input  logic [31:0]      pc,
  input  logic             redirect,
  input  logic [31:0]      target,
  output logic [31:0]      pc_next_c,
  output logic [31:0]      pc8_c,
  output logic [IM_AW-1:0] addr_next_c,
  output logic             fault_c
);
  // Upper bound computed in 33 bits so a window touching 2^32 does not wrap
  localparam logic [32:0] IM_END = 33'(IM_BASE) + (33'd4 << IM_AW);

  always_comb begin
    pc_next_c   = redirect ? target : pc + 32'd4;
    pc8_c       = pc + 32'd8;
    addr_next_c = IM_AW'((pc_next_c - IM_BASE) >> 2);
    fault_c     = (pc_next_c[1:0] != 2'b00) || (pc_next_c < IM_BASE) ||
                  ({1'b0, pc_next_c} >= IM_END);
  end
endmodule

// File: rtl/fetch_fd_stage.sv
// MIPS fetch stage: PC register, F/D pipeline register, stall counter and BOOT/RUN/HALT control.
module fetch_fd_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int unsigned IM_AW    = IM_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  fetch_fd_stage_if.master  bus
);
  localparam fd_t              FD_RESET   = '{ir: NOP, pc: 32'd0, pc8: 32'd8, valid: 1'b0};
  localparam logic [IM_AW-1:0] ADDR_RESET = IM_AW'((PC_RESET - IM_BASE) >> 2);

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [IM_AW-1:0] addr_q, addr_d;
  fd_t              fd_q, fd_d;
  logic             fault_q, fault_d;
  logic [31:0]      cnt_q, cnt_d;

  logic             redirect_c;
  logic [31:0]      pc_next_c, pc8_c;
  logic [IM_AW-1:0] addr_next_c;
  logic             fault_c;
  fd_t              fetch_c;

  assign redirect_c = bus.redirect_D && (state_q == ST_RUN);
  assign fetch_c    = '{ir: bus.im_rdata, pc: pc_q, pc8: pc8_c, valid: 1'b1};

  pc_gen #(.IM_BASE(IM_BASE), .IM_AW(IM_AW)) u_pc_gen (
    .pc          (pc_q),
    .redirect    (redirect_c),
    .target      (bus.target_D),
    .pc_next_c   (pc_next_c),
    .pc8_c       (pc8_c),
    .addr_next_c (addr_next_c),
    .fault_c     (fault_c)
  );

  // Next-state and register-load decisions
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    fd_d    = fd_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_BOOT: begin
        fd_d    = fetch_c;
        pc_d    = pc_next_c;
        addr_d  = addr_next_c;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.pause) begin
          if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        end else begin
          fd_d   = fetch_c;
          pc_d   = pc_next_c;
          addr_d = addr_next_c;
          if (fault_c) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        // Drain D with nops; PC and link values stay for post-mortem
        fd_d.ir    = NOP;
        fd_d.valid = 1'b0;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= PC_RESET;
      addr_q  <= ADDR_RESET;
      fd_q    <= FD_RESET;
      fault_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      fd_q    <= fd_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.im_addr   = addr_q;
  assign bus.PC_F      = pc_q;
  assign bus.IR_D      = fd_q.ir;
  assign bus.PC_D      = fd_q.pc;
  assign bus.PC8_D     = fd_q.pc8;
  assign bus.valid_D   = fd_q.valid;
  assign bus.fault     = fault_q;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_fetch_fd_stage.sv
// Randomized self-checking bench for fetch_fd_stage against a behavioural fetch model.
module tb_fetch_fd_stage;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [31:0] IM_BYTES = 32'd4096;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] imem [1024];

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  logic [31:0] m_pc, m_ir, m_pcd, m_pc8, m_cnt;
  logic        m_vld, m_fault, m_boot, m_halt;

  fetch_fd_stage_if #(.IM_AW(10)) bus ();

  fetch_fd_stage #(.PC_RESET(32'h0000_3000), .IM_BASE(32'h0000_3000), .IM_AW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.im_rdata = imem[bus.im_addr];

  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    logic [9:0] idx;
    idx = 10'((a - BASE) >> 2);
    return imem[idx];
  endfunction

  function automatic logic [171:0] obs();
    return {bus.PC_F, bus.IR_D, bus.PC_D, bus.PC8_D, bus.stall_cnt, bus.im_addr, bus.valid_D, bus.fault};
  endfunction

  function automatic logic [171:0] expv();
    return {m_pc, m_ir, m_pcd, m_pc8, m_cnt, 10'((m_pc - BASE) >> 2), m_vld, m_fault};
  endfunction

  // One clock of the architectural fetch behaviour
  task automatic model_step(input logic rst, input logic p, input logic r, input logic [31:0] t);
    logic [31:0] nxt;
    if (!rst) begin
      m_pc = BASE; m_ir = 32'd0; m_pcd = 32'd0; m_pc8 = 32'd8; m_cnt = 32'd0;
      m_vld = 1'b0; m_fault = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
    end else if (m_halt) begin
      m_ir = 32'd0; m_vld = 1'b0;
    end else if (m_boot || !p) begin
      m_ir = im_word(m_pc); m_pcd = m_pc; m_pc8 = m_pc + 32'd8; m_vld = 1'b1;
      nxt = (!m_boot && r) ? t : m_pc + 32'd4;
      if (!m_boot && (nxt % 4 != 0 || nxt < BASE || nxt >= BASE + IM_BYTES)) begin
        m_fault = 1'b1; m_halt = 1'b1;
      end
      m_pc = nxt; m_boot = 1'b0;
    end else if (m_cnt != 32'hFFFF_FFFF) begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic tick(input logic rst, input logic p, input logic r, input logic [31:0] t);
    @(negedge clk);
    reset = rst; bus.pause = p; bus.redirect_D = r; bus.target_D = t;
    @(posedge clk);
    model_step(rst, p, r, t);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    logic [171:0] want;
    tick(1'b0, 1'b1, 1'b1, 32'h3100);
    tick(1'b0, 1'b1, 1'b1, 32'h3100);
    want = {32'h3000, 32'd0, 32'd0, 32'd8, 32'd0, 10'd0, 1'b0, 1'b0};
    vectors++;
    if (obs() !== want) begin miscompares++; $display("FAIL reset_state got=%h want=%h", obs(), want); end
    vectors++;
    if (obs() !== expv()) begin miscompares++; $display("FAIL reset_model got=%h want=%h", obs(), expv()); end
    // boot edge ignores pause and redirect
    tick(1'b1, 1'b1, 1'b1, 32'h3100);
    want = {32'h3004, 32'h3C01_1234, 32'h3000, 32'h3008, 32'd0, 10'd1, 1'b1, 1'b0};
    vectors++;
    if (obs() !== want) begin miscompares++; $display("FAIL boot_fetch got=%h want=%h", obs(), want); end
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (bus.IR_D !== 32'h3421_5678 || bus.PC_D !== 32'h3004 || obs() !== expv()) begin
      miscompares++; $display("FAIL second_fetch got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_pause();
    logic [31:0] pc_hold, ir_hold;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    pc_hold = bus.PC_F; ir_hold = bus.IR_D;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1, BASE + 32'(4 * $urandom_range(0, 500)));
      vectors++;
      if (bus.PC_F !== pc_hold || bus.IR_D !== ir_hold || obs() !== expv()) begin
        miscompares++; $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, obs(), expv());
      end
    end
    vectors++;
    if (bus.stall_cnt !== 32'd3) begin miscompares++; $display("FAIL stall_cnt got=%0d want=3", bus.stall_cnt); end
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (bus.PC_D !== pc_hold || bus.PC_F !== pc_hold + 32'd4 || obs() !== expv()) begin
      miscompares++; $display("FAIL pause_resume got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_branch();
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 1'b1, 32'h3020);
    vectors++;
    if (bus.PC_D !== 32'h300C || bus.IR_D !== imem[3] || bus.PC_F !== 32'h3020 || obs() !== expv()) begin
      miscompares++; $display("FAIL branch_delay_slot got=%h want=%h", obs(), expv());
    end
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (bus.PC_D !== 32'h3020 || bus.IR_D !== imem[8] || bus.PC8_D !== 32'h3028 || obs() !== expv()) begin
      miscompares++; $display("FAIL branch_target got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_redirect_pause();
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b1, 32'h3040);
      vectors++;
      if (bus.PC_F !== 32'h300C || bus.PC_D !== 32'h3008 || obs() !== expv()) begin
        miscompares++; $display("FAIL redir_paused cyc=%0d got=%h want=%h", i, obs(), expv());
      end
    end
    tick(1'b1, 1'b0, 1'b1, 32'h3040);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (bus.PC_D !== 32'h3040 || bus.PC_F !== 32'h3044 || obs() !== expv()) begin
      miscompares++; $display("FAIL redir_unpaused got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_fault();
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 32'h3002);
    vectors++;
    if (bus.fault !== 1'b1 || bus.PC_F !== 32'h3002 || bus.valid_D !== 1'b1 || bus.PC_D !== 32'h3004 ||
        obs() !== expv()) begin
      miscompares++; $display("FAIL fault_set got=%h want=%h", obs(), expv());
    end
    tick(1'b1, 1'b0, 1'b1, 32'h3000);
    vectors++;
    if (bus.IR_D !== 32'd0 || bus.valid_D !== 1'b0 || bus.PC_F !== 32'h3002 || bus.PC_D !== 32'h3004 ||
        obs() !== expv()) begin
      miscompares++; $display("FAIL halt_drain got=%h want=%h", obs(), expv());
    end
    tick(1'b1, 1'b1, 1'b1, 32'h3000);
    vectors++;
    if (bus.stall_cnt !== 32'd0 || bus.PC_F !== 32'h3002 || obs() !== expv()) begin
      miscompares++; $display("FAIL halt_ignores got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_bounds();
    logic [31:0] tgt [4] = '{32'h2FFC, 32'h4000, 32'h3FFC, 32'h3FF8};
    logic        flt [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      tick(1'b1, 1'b0, 1'b1, tgt[i]);
      vectors++;
      if (bus.fault !== flt[i] || bus.PC_F !== tgt[i] || obs() !== expv()) begin
        miscompares++; $display("FAIL bound_%0h got=%h want=%h", tgt[i], obs(), expv());
      end
    end
    // sequential fetch walks off the top of IM
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (bus.fault !== 1'b1 || bus.PC_F !== 32'h4000 || obs() !== expv()) begin
      miscompares++; $display("FAIL seq_overrun got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_random();
    logic p, r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      tick(1'b1, p, r, BASE + 32'(4 * $urandom_range(0, 1000)));
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [171:0] want;
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b1, 32'h3020);
    want = {32'h3000, 32'd0, 32'd0, 32'd8, 32'd0, 10'd0, 1'b0, 1'b0};
    vectors++;
    if (obs() !== want || obs() !== expv()) begin
      miscompares++; $display("FAIL reset_mid got=%h want=%h", obs(), want);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    imem[0] = 32'h3C01_1234;
    imem[1] = 32'h3421_5678;
    reset = 1'b0; bus.pause = 1'b0; bus.redirect_D = 1'b0; bus.target_D = 32'd0;
    test_reset();
    test_pause();
    test_branch();
    test_redirect_pause();
    test_fault();
    test_bounds();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
